// File: rtl/vector_lane_sequencer.sv
// Sequences 256-bit vector FP ops (VADD, SMUL, VDOT) one 16-bit lane per cycle through a shared scalar ALU lane.
// Optional: define VLS_VDOT_EN to build the dot-product path (DOT_MUL/DOT_ACC states, acc/prod registers).
module vector_lane_sequencer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               opcode,
  input  logic [LANES*LANE_W-1:0]  vec_a,
  input  logic [LANES*LANE_W-1:0]  vec_b,
  input  logic [LANE_W-1:0]        scalar,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [LANES*LANE_W-1:0]  result,
  output logic [LANE_W-1:0]        lane_op_1,
  output logic [LANE_W-1:0]        lane_op_2,
  output logic [3:0]               lane_opcode,
  input  logic [LANE_W-1:0]        lane_result
);

  localparam int VW    = LANES * LANE_W;
  localparam int IDX_W = $clog2(LANES);

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_NOP  = 4'b1111;
`ifdef VLS_VDOT_EN
  localparam logic [3:0] OP_VDOT = 4'b0001;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LANE,
`ifdef VLS_VDOT_EN
    S_DOT_MUL,
    S_DOT_ACC,
`endif
    S_DONE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         opc_q;
  logic [VW-1:0]      a_q;
  logic [VW-1:0]      b_q;
  logic [LANE_W-1:0]  scalar_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [VW-1:0]      result_q;
`ifdef VLS_VDOT_EN
  logic [LANE_W-1:0]  acc_q;
  logic [LANE_W-1:0]  prod_q;
`endif

  logic [LANE_W-1:0]  a_lane;
  logic [LANE_W-1:0]  b_lane;
  logic               last_lane;

  assign a_lane    = a_q[int'(idx_q)*LANE_W +: LANE_W];
  assign b_lane    = b_q[int'(idx_q)*LANE_W +: LANE_W];
  assign last_lane = (idx_q == IDX_W'(LANES - 1));

  // ALU lane inputs are decoded from registered state so lane_result settles within the same cycle.
  always_comb begin
    lane_op_1   = '0;
    lane_op_2   = '0;
    lane_opcode = OP_NOP;
    case (state_q)
      S_LANE: begin
        lane_op_2 = b_lane;
        if (opc_q == OP_SMUL) begin
          lane_op_1   = scalar_q;
          lane_opcode = OP_SMUL;
        end else begin
          lane_op_1   = a_lane;
          lane_opcode = OP_VADD;
        end
      end
`ifdef VLS_VDOT_EN
      S_DOT_MUL: begin
        lane_op_1   = a_lane;
        lane_op_2   = b_lane;
        lane_opcode = OP_VDOT;
      end
      S_DOT_ACC: begin
        lane_op_1   = acc_q;
        lane_op_2   = prod_q;
        lane_opcode = OP_VADD;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
`ifdef VLS_VDOT_EN
      acc_q    <= '0;
      prod_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            opc_q    <= opcode;
            a_q      <= vec_a;
            b_q      <= vec_b;
            scalar_q <= scalar;
            idx_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
`ifdef VLS_VDOT_EN
            acc_q    <= '0;
`endif
            case (opcode)
              OP_VADD, OP_SMUL: state_q <= S_LANE;
`ifdef VLS_VDOT_EN
              OP_VDOT: begin
                state_q  <= S_DOT_MUL;
                result_q <= '0;
              end
`endif
              default: begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                err_q    <= 1'b1;
                result_q <= '0;
              end
            endcase
          end
        end
        S_LANE: begin
          result_q[int'(idx_q)*LANE_W +: LANE_W] <= lane_result;
          if (last_lane) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
`ifdef VLS_VDOT_EN
        S_DOT_MUL: begin
          prod_q  <= lane_result;
          state_q <= S_DOT_ACC;
        end
        S_DOT_ACC: begin
          acc_q    <= lane_result;
          result_q <= VW'(lane_result);
          if (last_lane) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_DOT_MUL;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Bench for vector_lane_sequencer: stand-in ALU lane, lane-level reference model, scoreboard queue and done monitor.
// Honours VLS_VDOT_EN the same way the design does.
module tb_vector_lane_sequencer;
  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int VW     = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        opcode;
  logic [VW-1:0]     vec_a, vec_b;
  logic [15:0]       scalar;
  logic              busy, done, err;
  logic [VW-1:0]     result;
  logic [15:0]       lane_op_1, lane_op_2, lane_result;
  logic [3:0]        lane_opcode;

  vector_lane_sequencer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .vec_a(vec_a), .vec_b(vec_b),
    .scalar(scalar), .busy(busy), .done(done), .err(err), .result(result),
    .lane_op_1(lane_op_1), .lane_op_2(lane_op_2), .lane_opcode(lane_opcode),
    .lane_result(lane_result)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Stand-in ALU lane: non-commutative add so swapped operands show up.
  function automatic logic [15:0] alu_add(input logic [15:0] x, input logic [15:0] y);
    return x + {y[7:0], y[15:8]};
  endfunction
  function automatic logic [15:0] alu_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = x * y;
    return p[15:0] ^ 16'h0101;
  endfunction
  always_comb begin
    case (lane_opcode)
      4'h0:       lane_result = alu_add(lane_op_1, lane_op_2);
      4'h1, 4'h2: lane_result = alu_mul(lane_op_1, lane_op_2);
      default:    lane_result = 16'h0;
    endcase
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [VW:0]  exp_q[$];
  int           exp_cyc_q[$];
  logic [15:0]  cur_scalar = 16'h0;

  task automatic check(input string name, input logic [VW:0] act, input logic [VW:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: whole-vector result from the op rules; bit VW carries err.
  function automatic void model(input logic [3:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                input logic [15:0] s, output logic [VW:0] e, output int lat);
    logic [15:0] acc;
    e = '0;
    case (op)
      4'h0: begin
        for (int k = 0; k < LANES; k++) e[k*16 +: 16] = alu_add(a[k*16 +: 16], b[k*16 +: 16]);
        lat = LANES + 1;
      end
      4'h2: begin
        for (int k = 0; k < LANES; k++) e[k*16 +: 16] = alu_mul(s, b[k*16 +: 16]);
        lat = LANES + 1;
      end
`ifdef VLS_VDOT_EN
      4'h1: begin
        acc = 16'h0;
        for (int k = 0; k < LANES; k++) acc = alu_add(acc, alu_mul(a[k*16 +: 16], b[k*16 +: 16]));
        e[15:0] = acc;
        lat = 2 * LANES + 1;
      end
`endif
      default: begin
        e[VW] = 1'b1;
        lat = 1;
      end
    endcase
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // driver: start stays high (with these operands) until an IDLE cycle accepts it
  task automatic issue(input logic [3:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [15:0] s);
    logic [VW:0] e;
    int lat;
    int guard;
    @(negedge clk);
    start = 1'b1; opcode = op; vec_a = a; vec_b = b; scalar = s;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: busy=%0b after %0d cycles, required 0", busy, guard);
      start = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(op, a, b, s, e, lat);
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + lat - 1);
    cur_scalar = s;
    @(negedge clk);
    start = 1'b0; opcode = 4'($urandom); vec_a = rand_vec(); vec_b = rand_vec(); scalar = 16'($urandom);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && lane_opcode == 4'h2)
        check("smul_op1", (VW+1)'(lane_op_1), (VW+1)'(cur_scalar));
      if (done) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
        end else begin
          logic [VW:0] e;
          int c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("done_cycle", (VW+1)'(cyc), (VW+1)'(c));
          check("err_result", {err, result}, e);
          check("done_nop", (VW+1)'(lane_opcode), (VW+1)'(4'hF));
        end
      end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
        n_tests++; n_fail++;
        $display("FAIL done_timeout: no done by cycle %0d, required at %0d", cyc, exp_cyc_q[0]);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    logic [VW-1:0] ones;
    int guard;
    ones = {LANES{16'h3C00}};
    rst = 1'b1; start = 1'b0; opcode = 4'h0; vec_a = '0; vec_b = '0; scalar = 16'h0;
    #12;
    check("rst_busy", (VW+1)'(busy), '0);
    check("rst_done", (VW+1)'(done), '0);
    check("rst_err_result", {err, result}, '0);
    check("rst_lane_ops", (VW+1)'({lane_op_1, lane_op_2}), '0);
    check("rst_lane_opcode", (VW+1)'(lane_opcode), (VW+1)'(4'hF));
    @(negedge clk);
    rst = 1'b0;

    issue(4'h0, ones, ones, 16'h0);          // VADD
    issue(4'h2, rand_vec(), ones, 16'h4000); // SMUL
    issue(4'h1, ones, ones, 16'h0);          // VDOT (unsupported without the macro)
    issue(4'h3, rand_vec(), rand_vec(), 16'h1234);
    issue(4'h0, rand_vec(), rand_vec(), 16'h0);

    // start held with other operands while busy and through DONE
    issue(4'h0, rand_vec(), rand_vec(), 16'h0);
    repeat (2) @(negedge clk);
    issue(4'h2, rand_vec(), rand_vec(), 16'($urandom));

    for (int i = 0; i < 12; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 3))
        0: op = 4'h0;
        1: op = 4'h1;
        2: op = 4'h2;
        default: op = 4'($urandom_range(0, 15));
      endcase
      issue(op, rand_vec(), rand_vec(), 16'($urandom));
    end

    // reset in the middle of a VADD aborts without a done pulse
    issue(4'h0, rand_vec(), rand_vec(), 16'h0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", (VW+1)'(busy), '0);
    check("abort_done", (VW+1)'(done), '0);
    check("abort_result", {err, result}, '0);
    check("abort_lane_opcode", (VW+1)'(lane_opcode), (VW+1)'(4'hF));
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(4'h0, rand_vec(), rand_vec(), 16'h0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
